serial_link_phy_train_ctrl: RTL and testbench



---
 rtl/serial_link_pkg.sv | 16 +
 rtl/serial_link_phy_train_match.sv | 56 +++++
 rtl/serial_link_phy_train_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_serial_link_phy_train_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared types and constants for the serial-link PHY training controller.
//   phy_train_state_e   : training FSM state encoding
//   DefaultTrainPattern : default training word (the ACK word is its inverse)
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PATTERN = 3'd1,
    ACK     = 3'd2,
    UP      = 3'd3,
    ERROR   = 3'd4
  } phy_train_state_e;

  localparam logic [15:0] DefaultTrainPattern = 16'hA5C3;

endpackage

// File: rtl/serial_link_phy_train_match.sv
// Consecutive-match counter used by both training phases.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : synchronous clear (dominates everything else)
//   hs_i           : an RX beat handshakes this cycle
//   tol_inc_i      : 1 = the tolerated word also counts, 0 = it only holds
//   data_i         : handshaked RX word
//   expected_i     : word that always advances the count
//   tolerated_i    : word that holds (or advances, with tol_inc_i) the count
//   done_o         : this handshake completes the NumMatch-th match
module serial_link_phy_train_match #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned NumMatch  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 hs_i,
  input  logic                 tol_inc_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [DataWidth-1:0] expected_i,
  input  logic [DataWidth-1:0] tolerated_i,
  output logic                 done_o
);

  localparam int unsigned CntW = $clog2(NumMatch + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hit_exp, hit_tol, inc;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    hit_exp = (data_i == expected_i);
    hit_tol = (data_i == tolerated_i);
    inc     = hs_i & (hit_exp | (hit_tol & tol_inc_i));
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (hs_i) begin
      if (inc)          cnt_d = cnt_q + 1'b1;
      else if (!hit_tol) cnt_d = '0;
    end
    // Completion is flagged on the matching beat itself so the phase change
    // lands on the same edge that would have stored NumMatch.
    done_o = inc & (cnt_q == CntW'(NumMatch - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_link_phy_train_ctrl.sv
// Link bring-up controller between the data-link layer and one serial PHY
// channel. Trains the link (PATTERN phase, then ACK phase) against the remote
// controller, then passes user TX/RX beats straight through.
// Ports:
//   clk_i, rst_ni                    : clock, asynchronous active-low reset
//   en_i                             : level enable, low returns to IDLE
//   usr_tx_data_i/valid_i/ready_o    : user TX stream
//   usr_rx_data_o/valid_o/ready_i    : user RX stream
//   phy_tx_data_o/valid_o/ready_i    : PHY TX stream (valid gates fwd clock)
//   phy_rx_data_i/valid_i/ready_o    : PHY RX stream
//   link_up_o, train_err_o           : state UP / state ERROR
// Optional (macro SERIAL_LINK_PHY_TRAIN_STATS_EN):
//   train_attempts_o, timeouts_o     : saturating training statistics
module serial_link_phy_train_ctrl
  import serial_link_pkg::*;
#(
  parameter int unsigned                PhyDataWidth  = 16,
  parameter logic [PhyDataWidth-1:0]    TrainPattern  = PhyDataWidth'(DefaultTrainPattern),
  parameter int unsigned                NumMatch      = 4,
  parameter int unsigned                TimeoutCycles = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic [PhyDataWidth-1:0] usr_tx_data_i,
  input  logic                    usr_tx_valid_i,
  output logic                    usr_tx_ready_o,
  output logic [PhyDataWidth-1:0] usr_rx_data_o,
  output logic                    usr_rx_valid_o,
  input  logic                    usr_rx_ready_i,
  output logic [PhyDataWidth-1:0] phy_tx_data_o,
  output logic                    phy_tx_valid_o,
  input  logic                    phy_tx_ready_i,
  input  logic [PhyDataWidth-1:0] phy_rx_data_i,
  input  logic                    phy_rx_valid_i,
  output logic                    phy_rx_ready_o,
  output logic                    link_up_o,
  output logic                    train_err_o
`ifdef SERIAL_LINK_PHY_TRAIN_STATS_EN
  ,
  output logic [15:0]             train_attempts_o,
  output logic [15:0]             timeouts_o
`endif
);

  localparam logic [2:0] StIdle    = IDLE;
  localparam logic [2:0] StPattern = PATTERN;
  localparam logic [2:0] StAck     = ACK;
  localparam logic [2:0] StUp      = UP;
  localparam logic [2:0] StError   = ERROR;

  localparam int unsigned TmoW = $clog2(TimeoutCycles);

  logic [2:0]              state_q, state_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic                    training, timeout, rx_hs, match_done, match_clear;
  logic [PhyDataWidth-1:0] exp_word;

  assign training = (state_q == StPattern) | (state_q == StAck);
  // The counter stops at TimeoutCycles-1; seeing it there while still
  // training means the whole PATTERN+ACK budget has been spent.
  assign timeout  = training & (tmo_q == TmoW'(TimeoutCycles - 1));
  assign rx_hs    = phy_rx_valid_i & phy_rx_ready_o;

  // PATTERN counts both training words (the remote may already be in ACK);
  // ACK counts only the inverse word and merely holds on the pattern word.
  assign exp_word    = (state_q == StAck) ? ~TrainPattern : TrainPattern;
  assign match_clear = ~en_i | ~training | timeout | match_done;

  serial_link_phy_train_match #(
    .DataWidth (PhyDataWidth),
    .NumMatch  (NumMatch)
  ) u_match (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (match_clear),
    .hs_i        (rx_hs),
    .tol_inc_i   (state_q == StPattern),
    .data_i      (phy_rx_data_i),
    .expected_i  (exp_word),
    .tolerated_i (~exp_word),
    .done_o      (match_done)
  );

  // Next state; timeout is tested before match completion so it wins.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    state_d = StPattern;
        StPattern: if (timeout) state_d = StError; else if (match_done) state_d = StAck;
        StAck:     if (timeout) state_d = StError; else if (match_done) state_d = StUp;
        StUp:      state_d = StUp;
        StError:   state_d = StError;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if (!en_i || !training) tmo_d = '0;
    else if (!timeout)      tmo_d = tmo_q + 1'b1;
  end

  // Moore decode of state, except the zero-latency pass-through in UP.
  always_comb begin
    phy_tx_data_o  = '0;
    phy_tx_valid_o = 1'b0;
    phy_rx_ready_o = 1'b0;
    usr_tx_ready_o = 1'b0;
    usr_rx_data_o  = '0;
    usr_rx_valid_o = 1'b0;
    link_up_o      = 1'b0;
    train_err_o    = 1'b0;
    case (state_q)
      StPattern: begin
        phy_tx_valid_o = 1'b1;
        phy_tx_data_o  = TrainPattern;
        phy_rx_ready_o = 1'b1;
      end
      StAck: begin
        phy_tx_valid_o = 1'b1;
        phy_tx_data_o  = ~TrainPattern;
        phy_rx_ready_o = 1'b1;
      end
      StUp: begin
        link_up_o      = 1'b1;
        phy_tx_data_o  = usr_tx_data_i;
        phy_tx_valid_o = usr_tx_valid_i;
        usr_tx_ready_o = phy_tx_ready_i;
        usr_rx_data_o  = phy_rx_data_i;
        usr_rx_valid_o = phy_rx_valid_i;
        phy_rx_ready_o = usr_rx_ready_i;
      end
      StError: begin
        train_err_o    = 1'b1;
        phy_rx_ready_o = 1'b1;  // keep draining so the CDC FIFO cannot back up
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef SERIAL_LINK_PHY_TRAIN_STATS_EN
  // Statistics survive en_i toggling; only rst_ni clears them.
  logic [15:0] attempts_q, attempts_d, timeouts_q, timeouts_d;

  always_comb begin
    attempts_d = attempts_q;
    timeouts_d = timeouts_q;
    if (state_q == StIdle && state_d == StPattern && attempts_q != 16'hFFFF)
      attempts_d = attempts_q + 16'd1;
    if (state_q != StError && state_d == StError && timeouts_q != 16'hFFFF)
      timeouts_d = timeouts_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      attempts_q <= '0;
      timeouts_q <= '0;
    end else begin
      attempts_q <= attempts_d;
      timeouts_q <= timeouts_d;
    end
  end

  assign train_attempts_o = attempts_q;
  assign timeouts_o       = timeouts_q;
`endif

endmodule

// File: tb/tb_serial_link_phy_train_ctrl.sv
module tb_serial_link_phy_train_ctrl;

  localparam logic [15:0] TP  = 16'hA5C3;
  localparam logic [15:0] NTP = 16'h5A3C;
  localparam int NM  = 4;
  localparam int TMO = 64;

  localparam int P_IDLE = 0, P_PAT = 1, P_ACK = 2, P_UP = 3, P_ERR = 4;

  typedef struct packed {
    logic        link_up;
    logic        err;
    logic        txv;
    logic [15:0] txd;
    logic        utr;
    logic        urv;
    logic [15:0] urd;
    logic        prr;
  } outs_t;

  typedef struct {
    logic        en;
    logic        rxv;
    logic [15:0] rxd;
    logic        exp_txv;
    logic [15:0] exp_txd;
    logic        exp_up;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] usr_tx_data;
  logic        usr_tx_valid, usr_tx_ready;
  logic [15:0] usr_rx_data;
  logic        usr_rx_valid, usr_rx_ready;
  logic [15:0] phy_tx_data;
  logic        phy_tx_valid, phy_tx_ready;
  logic [15:0] phy_rx_data, rx_data_drv;
  logic        phy_rx_valid, rx_valid_drv, phy_rx_ready;
  logic        link_up, train_err;
  logic        loopback;
  outs_t       dut_o, obs;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: training phase, consecutive-match run, cycles spent training
  int m_phase, m_match, m_tmo;

  always #5 clk = ~clk;

  assign phy_rx_data  = loopback ? phy_tx_data  : rx_data_drv;
  assign phy_rx_valid = loopback ? phy_tx_valid : rx_valid_drv;
  assign dut_o = {link_up, train_err, phy_tx_valid, phy_tx_data, usr_tx_ready,
                  usr_rx_valid, usr_rx_data, phy_rx_ready};

`ifdef SERIAL_LINK_PHY_TRAIN_STATS_EN
  logic [15:0] train_attempts, timeouts;
`endif

  serial_link_phy_train_ctrl #(
    .PhyDataWidth  (16),
    .TrainPattern  (TP),
    .NumMatch      (NM),
    .TimeoutCycles (TMO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .usr_tx_data_i  (usr_tx_data),
    .usr_tx_valid_i (usr_tx_valid),
    .usr_tx_ready_o (usr_tx_ready),
    .usr_rx_data_o  (usr_rx_data),
    .usr_rx_valid_o (usr_rx_valid),
    .usr_rx_ready_i (usr_rx_ready),
    .phy_tx_data_o  (phy_tx_data),
    .phy_tx_valid_o (phy_tx_valid),
    .phy_tx_ready_i (phy_tx_ready),
    .phy_rx_data_i  (phy_rx_data),
    .phy_rx_valid_i (phy_rx_valid),
    .phy_rx_ready_o (phy_rx_ready),
    .link_up_o      (link_up),
    .train_err_o    (train_err)
`ifdef SERIAL_LINK_PHY_TRAIN_STATS_EN
    ,
    .train_attempts_o (train_attempts),
    .timeouts_o       (timeouts)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Expected outputs for the current model phase and bench-driven inputs,
  // plus the RX beat the DUT actually sees (loopback or driven).
  task automatic model_eval(output outs_t o, output logic rv, output logic [15:0] rd);
    o = '0;
    case (m_phase)
      P_PAT: begin o.txv = 1'b1; o.txd = TP;  o.prr = 1'b1; end
      P_ACK: begin o.txv = 1'b1; o.txd = NTP; o.prr = 1'b1; end
      P_UP:  begin o.link_up = 1'b1; o.txv = usr_tx_valid; o.txd = usr_tx_data;
                   o.utr = phy_tx_ready; o.prr = usr_rx_ready; end
      P_ERR: begin o.err = 1'b1; o.prr = 1'b1; end
      default: ;
    endcase
    rv = loopback ? o.txv : rx_valid_drv;
    rd = loopback ? o.txd : rx_data_drv;
    if (m_phase == P_UP) begin o.urv = rv; o.urd = rd; end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_match = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    outs_t o; logic rv; logic [15:0] rd; logic hs;
    model_eval(o, rv, rd);
    hs = rv & o.prr;
    if (!en) begin
      model_reset();
    end else if (m_phase == P_IDLE) begin
      m_phase = P_PAT; m_match = 0; m_tmo = 0;
    end else if (m_phase == P_PAT || m_phase == P_ACK) begin
      if (m_tmo + 1 >= TMO) begin
        m_phase = P_ERR; m_match = 0;
      end else begin
        m_tmo++;
        if (hs) begin
          if (rd == NTP || (rd == TP && m_phase == P_PAT)) m_match++;
          else if (rd != TP) m_match = 0;
        end
        if (m_match == NM) begin
          m_phase = (m_phase == P_PAT) ? P_ACK : P_UP;
          m_match = 0;
        end
      end
    end
  endtask

  // One clock: compare at the falling edge, step the model at the rising one.
  task automatic cycle();
    outs_t e; logic rv; logic [15:0] rd;
    @(negedge clk);
    model_eval(e, rv, rd);
    obs = dut_o;
    check("model_outs", obs, e);
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Count cycles (0 = current) until link_up (sel 0) or train_err (sel 1).
  task automatic wait_for(input int sel, input int budget, output int idx);
    idx = -1;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if ((sel == 0 && obs.link_up) || (sel == 1 && obs.err)) begin
        idx = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; loopback = 1'b0;
    usr_tx_data = '0; usr_tx_valid = 1'b0; usr_rx_ready = 1'b0; phy_tx_ready = 1'b0;
    rx_data_drv = '0; rx_valid_drv = 1'b0;
    model_reset();
    #1;
    check("reset_outs", dut_o, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t vecs[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    for (int i = 1; i <= 3; i++)
      vecs[i] = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 16'hA5C3, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'h0000, 1'b1, 16'hA5C3, 1'b0, 1'b0};
    for (int i = 5; i <= 8; i++)
      vecs[i] = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 16'hA5C3, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 16'h5A3C, 1'b1, 16'h5A3C, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h5A3C, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 16'h5A3C, 1'b0, 1'b0};
    for (int i = 12; i <= 14; i++)
      vecs[i] = '{1'b1, 1'b1, 16'h5A3C, 1'b1, 16'h5A3C, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    // Table: interrupted pattern run, then ACK with idle and tolerated beats.
    do_reset();
    foreach (vecs[i]) begin
      en = vecs[i].en; rx_valid_drv = vecs[i].rxv; rx_data_drv = vecs[i].rxd;
      cycle();
      check($sformatf("vec%0d", i), {obs.txv, obs.txd, obs.link_up, obs.err},
            {vecs[i].exp_txv, vecs[i].exp_txd, vecs[i].exp_up, vecs[i].exp_err});
    end

    // Loopback bring-up and user data pass-through.
    do_reset();
    loopback = 1'b1; en = 1'b1;
    wait_for(0, 30, idx);
    check("loopback_linkup_cycle", 64'(idx), 64'(9));
    usr_tx_data = 16'h1234; usr_tx_valid = 1'b1; usr_rx_ready = 1'b1; phy_tx_ready = 1'b1;
    cycle();
    check("loopback_phy_tx", {obs.txv, obs.txd}, {1'b1, 16'h1234});
    check("loopback_usr_rx", {obs.urv, obs.urd, obs.utr}, {1'b1, 16'h1234, 1'b1});

    // Reset asserted mid-ACK, then training restarts from zero.
    do_reset();
    loopback = 1'b1; en = 1'b1;
    repeat (6) cycle();
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", dut_o, '0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    wait_for(0, 30, idx);
    check("post_reset_linkup_cycle", 64'(idx), 64'(9));

    // Remote already answering with the ACK word.
    do_reset();
    rx_valid_drv = 1'b1; rx_data_drv = NTP; en = 1'b1;
    wait_for(0, 30, idx);
    check("remote_ack_linkup_cycle", 64'(idx), 64'(9));
    // Drop enable in UP with a beat held valid.
    usr_tx_valid = 1'b1; usr_tx_data = 16'hBEEF; phy_tx_ready = 1'b1; en = 1'b0;
    cycle();
    check("en_drop_last_beat", {obs.txv, obs.utr, obs.link_up}, 3'b111);
    cycle();
    check("en_drop_next", {obs.txv, obs.utr, obs.link_up}, 3'b000);

    // Stuck RX word: 64 training cycles, then ERROR.
    do_reset();
    rx_valid_drv = 1'b1; rx_data_drv = 16'hFFFF; en = 1'b1;
    wait_for(1, 100, idx);
    check("timeout_cycle", 64'(idx), 64'(65));
    check("timeout_tx_off", {obs.txv, obs.prr}, 2'b01);
    en = 1'b0;
    cycle(); cycle();
    check("err_to_idle", {obs.err, obs.txv, obs.prr}, 3'b000);
    en = 1'b1;
    cycle(); cycle();
    check("retrain_pattern", {obs.txv, obs.txd}, {1'b1, TP});

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      en = ($urandom_range(0, 199) != 0);
      r = $urandom_range(0, 9);
      rx_data_drv  = (r < 6) ? NTP : (r < 9) ? TP : 16'($urandom);
      rx_valid_drv = ($urandom_range(0, 3) != 0);
      usr_tx_data  = 16'($urandom);
      usr_tx_valid = 1'($urandom);
      usr_rx_ready = 1'($urandom);
      phy_tx_ready = 1'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
